// File: rtl/fuzzy_rule_scheduler_pkg.sv
// Shared types and constants for the fuzzy rule scheduler: FSM states, rule-entry layout, degree width.
// No logic; imported by the min stage and the top.
package fuzzy_rule_scheduler_pkg;

  localparam int DEG_W     = 32;
  localparam int LABEL_W   = 2;
  localparam int RULE_W    = 98;
  localparam int LABEL_LSB = 96;
  localparam int DEG0_LSB  = 64;
  localparam int DEG1_LSB  = 32;
  localparam int DEG2_LSB  = 0;

  // Most negative degree, so any real rule result beats an untouched label.
  localparam logic signed [DEG_W-1:0] ACC_INIT = 32'sh8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [LABEL_W-1:0]       label;
    logic signed [DEG_W-1:0]  deg;
  } min_res_t;

  function automatic logic signed [DEG_W-1:0] smin(input logic signed [DEG_W-1:0] a,
                                                   input logic signed [DEG_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

endpackage

// File: rtl/rule_min_stage.sv
// Registered signed minimum over the first dim antecedent degrees of a rule entry, carrying its label.
// Latency 1 cycle; no backpressure, one result per valid input.
module rule_min_stage
  import fuzzy_rule_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [3:0]        dim,
  input  logic [RULE_W-1:0] entry,
  output logic              out_vld,
  output min_res_t          out_res
);

  logic signed [DEG_W-1:0] deg0;
  logic signed [DEG_W-1:0] deg1;
  logic signed [DEG_W-1:0] deg2;
  logic signed [DEG_W-1:0] min_deg;

  always_comb begin
    deg0 = $signed(entry[DEG0_LSB +: DEG_W]);
    deg1 = $signed(entry[DEG1_LSB +: DEG_W]);
    deg2 = $signed(entry[DEG2_LSB +: DEG_W]);
    case (dim)
      4'd2:    min_deg = smin(deg0, deg1);
      4'd3:    min_deg = smin(smin(deg0, deg1), deg2);
      default: min_deg = deg0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld <= 1'b0;
      out_res <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_res.label <= entry[LABEL_LSB +: LABEL_W];
        out_res.deg   <= min_deg;
      end
    end
  end

endmodule

// File: rtl/fuzzy_rule_scheduler.sv
// Fuzzy inference pass: reads rule_count rules, takes per-rule min of antecedents, max-aggregates per label.
// Result valid rule_count+3 cycles after start; held in DONE until agg_ready (valid/ready).
module fuzzy_rule_scheduler
  import fuzzy_rule_scheduler_pkg::*;
#(
  parameter int MAX_RULES  = 16,
  parameter int NUM_LABELS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  input_dim,
  input  logic [4:0]                  rule_count,
  output logic                        rule_rd_en,
  output logic [3:0]                  rule_addr,
  input  logic [RULE_W-1:0]           rule_data,
  output logic                        busy,
  output logic                        cfg_error,
  output logic [NUM_LABELS*DEG_W-1:0] agg_degree,
  output logic                        agg_valid,
  input  logic                        agg_ready
);

  state_t                  state_q;
  state_t                  state_d;
  logic [3:0]              addr_q;
  logic [3:0]              dim_q;
  logic [4:0]              cnt_q;
  logic                    rd_vld_q;
  logic                    min_vld;
  min_res_t                min_res;
  logic signed [DEG_W-1:0] acc_q [NUM_LABELS];
  logic                    cfg_ok;
  logic                    accept;
  logic                    last_addr;

  assign cfg_ok    = (input_dim != 4'd0) && (input_dim <= 4'd3) &&
                     (rule_count != 5'd0) && (int'(rule_count) <= MAX_RULES);
  assign accept    = (state_q == ST_IDLE) && start && cfg_ok;
  assign last_addr = ({1'b0, addr_q} == (cnt_q - 5'd1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)                  state_d = ST_FETCH;
      ST_FETCH: if (last_addr)               state_d = ST_DRAIN;
      ST_DRAIN: if (!rd_vld_q && !min_vld)   state_d = ST_DONE;
      ST_DONE:  if (agg_ready)               state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rule_rd_en = (state_q == ST_FETCH);
    rule_addr  = rule_rd_en ? addr_q : 4'd0;
    busy       = (state_q != ST_IDLE);
    agg_valid  = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q    <= '0;
      dim_q     <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      cfg_error <= 1'b0;
      for (int i = 0; i < NUM_LABELS; i++) acc_q[i] <= '0;
    end else begin
      cfg_error <= (state_q == ST_IDLE) && start && !cfg_ok;
      rd_vld_q  <= rule_rd_en;
      if (accept) begin
        dim_q  <= input_dim;
        cnt_q  <= rule_count;
        addr_q <= '0;
        for (int i = 0; i < NUM_LABELS; i++) acc_q[i] <= ACC_INIT;
      end else begin
        if (rule_rd_en && !last_addr) addr_q <= addr_q + 4'd1;
        // Strictly greater: a tie keeps the value already stored.
        for (int i = 0; i < NUM_LABELS; i++) begin
          if (min_vld && (min_res.label == LABEL_W'(i)) && (min_res.deg > acc_q[i]))
            acc_q[i] <= min_res.deg;
        end
      end
    end
  end

  rule_min_stage u_min (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_vld_q),
    .dim     (dim_q),
    .entry   (rule_data),
    .out_vld (min_vld),
    .out_res (min_res)
  );

  for (genvar g = 0; g < NUM_LABELS; g++) begin : g_agg
    assign agg_degree[g*DEG_W +: DEG_W] = acc_q[g];
  end

endmodule

// File: tb/tb_fuzzy_rule_scheduler.sv
// Self-checking bench: rule-table responder, reference model feeding a scoreboard queue, scenario tasks.
module tb_fuzzy_rule_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   input_dim = '0;
  logic [4:0]   rule_count = '0;
  logic         rule_rd_en;
  logic [3:0]   rule_addr;
  logic [97:0]  rule_data = '0;
  logic         busy;
  logic         cfg_error;
  logic [127:0] agg_degree;
  logic         agg_valid;
  logic         agg_ready = 1'b0;

  logic [97:0]  rule_mem [16];
  logic [127:0] exp_q [$];
  logic [3:0]   addr_log [$];
  int           rd_cnt = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic         rd_en_s = 1'b0;
  logic [3:0]   addr_s = '0;

  localparam logic [31:0] NEG = 32'h8000_0000;

  fuzzy_rule_scheduler #(.MAX_RULES(16), .NUM_LABELS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .input_dim  (input_dim),
    .rule_count (rule_count),
    .rule_rd_en (rule_rd_en),
    .rule_addr  (rule_addr),
    .rule_data  (rule_data),
    .busy       (busy),
    .cfg_error  (cfg_error),
    .agg_degree (agg_degree),
    .agg_valid  (agg_valid),
    .agg_ready  (agg_ready)
  );

  always #5 clk = ~clk;

  // Capture the read request mid-cycle, answer it on the following rising edge.
  always @(negedge clk) begin
    rd_en_s = rule_rd_en;
    addr_s  = rule_addr;
    if (rule_rd_en === 1'b1) begin
      rd_cnt++;
      addr_log.push_back(rule_addr);
    end
  end

  always @(posedge clk) begin
    if (rd_en_s) rule_data <= rule_mem[addr_s];
    else         rule_data <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  function automatic logic [127:0] model(input int dim, input int cnt);
    logic signed [31:0] acc [4];
    logic signed [31:0] d0, d1, d2, m;
    logic [1:0]         lbl;
    for (int i = 0; i < 4; i++) acc[i] = NEG;
    for (int r = 0; r < cnt; r++) begin
      lbl = rule_mem[r][97:96];
      d0  = rule_mem[r][95:64];
      d1  = rule_mem[r][63:32];
      d2  = rule_mem[r][31:0];
      m   = d0;
      if (dim >= 2 && d1 < m) m = d1;
      if (dim >= 3 && d2 < m) m = d2;
      if (m > acc[lbl]) acc[lbl] = m;
    end
    return {acc[3], acc[2], acc[1], acc[0]};
  endfunction

  task automatic fill_mem(input int narrow, input logic [1:0] lbl_mask);
    logic [31:0] v [3];
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 3; k++)
        v[k] = narrow ? 32'($signed($urandom_range(0, 15)) - 8) : $urandom();
      rule_mem[r] = {2'($urandom_range(0, 3)) & lbl_mask, v[0], v[1], v[2]};
    end
  endtask

  task automatic run_pass(input logic [3:0] dim, input logic [4:0] cnt);
    logic [127:0] exp;
    int n;
    int rd0;
    int bad;
    rd0 = rd_cnt;
    addr_log.delete();
    input_dim = dim; rule_count = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy got %b want 1", busy); end
    n = 0;
    while (agg_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n !== int'(cnt) + 3) begin
      n_fail++; $display("FAIL pass_latency got %0d want %0d", n, int'(cnt) + 3);
    end
    bad = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== 4'(i)) bad++;
    n_checks++;
    if (rd_cnt - rd0 !== int'(cnt) || bad != 0) begin
      n_fail++; $display("FAIL pass_reads got %0d reads (%0d bad addr) want %0d", rd_cnt - rd0, bad, cnt);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL pass_scoreboard got empty queue want an entry");
    end else begin
      exp = exp_q.pop_front();
      if (agg_degree !== exp) begin
        n_fail++; $display("FAIL pass_agg got %h want %h", agg_degree, exp);
      end
    end
    agg_ready = 1'b1;
    @(posedge clk); #1;
    agg_ready = 1'b0;
    n_checks++;
    if (agg_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pass_release got valid=%b busy=%b want 0 0", agg_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({rule_rd_en, rule_addr, busy, cfg_error, agg_valid} !== 8'd0 || agg_degree !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got rd=%b addr=%0d busy=%b err=%b vld=%b agg=%h want all 0",
               rule_rd_en, rule_addr, busy, cfg_error, agg_valid, agg_degree);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || agg_valid !== 1'b0 || rule_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_release got busy=%b vld=%b rd=%b want 0", busy, agg_valid, rule_rd_en);
    end
  endtask

  task automatic test_single_rule;
    fill_mem(0, 2'b11);
    rule_mem[0] = {2'd1, 32'd40, 32'd10, 32'd25};
    exp_q.push_back({NEG, NEG, 32'd10, NEG});
    run_pass(4'd3, 5'd1);
  endtask

  task automatic test_dim2;
    fill_mem(0, 2'b11);
    rule_mem[0] = {2'd0, 32'd5,          32'd9, 32'hFFFF_FF9C};
    rule_mem[1] = {2'd0, 32'hFFFF_FFFD,  32'd7, 32'hFFFF_FF9C};
    rule_mem[2] = {2'd0, 32'd12,         32'd8, 32'hFFFF_FF9C};
    exp_q.push_back({NEG, NEG, NEG, 32'd8});
    run_pass(4'd2, 5'd3);
  endtask

  task automatic test_cfg_error;
    logic [3:0] dims [3] = '{4'd0, 4'd1, 4'd4};
    logic [4:0] cnts [3] = '{5'd1, 5'd17, 5'd2};
    int rd0;
    for (int k = 0; k < 3; k++) begin
      rd0 = rd_cnt;
      input_dim = dims[k]; rule_count = cnts[k]; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (cfg_error !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL cfg_pulse[%0d] got err=%b busy=%b want 1 0", k, cfg_error, busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (cfg_error !== 1'b0 || busy !== 1'b0 || rd_cnt != rd0) begin
        n_fail++; $display("FAIL cfg_after[%0d] got err=%b busy=%b reads=%0d want 0 0 0",
                           k, cfg_error, busy, rd_cnt - rd0);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] exp;
    int n;
    int rd0;
    fill_mem(1, 2'b11);
    exp = model(3, 2);
    exp_q.push_back(exp);
    input_dim = 4'd3; rule_count = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (agg_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    rd0 = rd_cnt;
    input_dim = 4'd1; rule_count = 5'd1; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (agg_valid !== 1'b1 || busy !== 1'b1 || agg_degree !== exp) begin
        n_fail++; $display("FAIL hold[%0d] got vld=%b busy=%b agg=%h want 1 1 %h",
                           k, agg_valid, busy, agg_degree, exp);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (rd_cnt != rd0 || cfg_error !== 1'b0) begin
      n_fail++; $display("FAIL hold_start_ignored got reads=%0d err=%b want 0 0", rd_cnt - rd0, cfg_error);
    end
    exp = exp_q.pop_front();
    agg_ready = 1'b1;
    @(posedge clk); #1;
    agg_ready = 1'b0;
    n_checks++;
    if (agg_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release got vld=%b busy=%b want 0 0", agg_valid, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || rule_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle got busy=%b rd=%b want 0 0", busy, rule_rd_en);
    end
  endtask

  task automatic test_mid_reset;
    fill_mem(0, 2'b11);
    input_dim = 4'd3; rule_count = 5'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({rule_rd_en, rule_addr, busy, cfg_error, agg_valid} !== 8'd0 || agg_degree !== 128'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got rd=%b addr=%0d busy=%b err=%b vld=%b agg=%h want all 0",
               rule_rd_en, rule_addr, busy, cfg_error, agg_valid, agg_degree);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    fill_mem(1, 2'b11);
    exp_q.push_back(model(2, 4));
    run_pass(4'd2, 5'd4);
  endtask

  task automatic test_back_to_back;
    int cnts [6] = '{16, 1, 7, 16, 3, 12};
    for (int p = 0; p < 6; p++) begin
      fill_mem(p % 2, (p == 2 || p == 5) ? 2'b10 : 2'b11);
      exp_q.push_back(model(p % 3 + 1, cnts[p]));
      run_pass(4'(p % 3 + 1), 5'(cnts[p]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_rule();
    test_dim2();
    test_cfg_error();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
